c17_bist_ctrl: RTL and testbench
================================

// Module: c17_bist_ctrl
// PURPOSE
//   Built-in self-test driver/observer for the c17 combinational benchmark.
//   Upstream stage: an LFSR generates pseudo-random vectors on pat_o for the c17 inputs.
//   Downstream stage: a MISR compacts the two c17 outputs from rsp_i into a signature.
//   At run end the signature is compared with a golden value; the pass/fail verdict is reported.
// PARAMETERS
//   N_PAT       31          patterns applied per run, 1..255 (>31 repeats the LFSR cycle)
//   LFSR_SEED   5'b00001    first pattern; must be non-zero
//   MISR_SEED   16'h0000    MISR value loaded at run start
//   GOLDEN_SIG  16'h0000    expected final signature; generated by the team's c17 C model
// PORTS
//   clk      in   1   single clock, rising edge
//   rst_n    in   1   asynchronous assert, active-low reset
//   start_i  in   1   run request, level-sampled; acted on only in IDLE or DONE
//   abort_i  in   1   cancels a run; returns the block to IDLE
//   rsp_i    in   2   c17 responses: [0]=gat_out22, [1]=gat_out23
//   pat_o    out  5   registered pattern to c17: [0]=gat1 [1]=gat2 [2]=gat3 [3]=gat6 [4]=gat7
//   busy_o   out  1   high while in RUN
//   done_o   out  1   sticky; high in DONE until the next start or abort
//   pass_o   out  1   valid while done_o=1; 1 when the final signature equals GOLDEN_SIG
//   sig_o    out  16  current MISR contents; final signature while done_o=1
// BEHAVIOUR
//   Reset: state=IDLE, pat_o=0, busy_o=0, done_o=0, pass_o=0, sig_o=0, cnt=0.
//     Reset mid-run aborts the run immediately; no partial verdict is kept.
//   States: IDLE, RUN, DONE (2-bit encoding).
//   IDLE/DONE with start_i=1 and abort_i=0 -> RUN:
//     pat_o<=LFSR_SEED, misr<=MISR_SEED, cnt<=0, busy_o<=1, done_o<=0, pass_o<=0.
//   RUN, every edge:
//     - MISR absorbs rsp_i for the pattern currently on pat_o. c17 is combinational,
//       so the response is valid in the same cycle.
//     - misr_next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ {14'b0, rsp_i}
//     - lfsr_next = {pat_o[3:0], pat_o[4]^pat_o[2]}   (x^5+x^3+1, period 31)
//     - pat_o<=lfsr_next, cnt<=cnt+1.
//   RUN on the edge where cnt==N_PAT-1 -> DONE:
//     misr<=misr_next, pass_o<=(misr_next==GOLDEN_SIG), done_o<=1, busy_o<=0, pat_o<=0.
//   Latency: done_o rises exactly N_PAT cycles after the edge that accepted start_i.
//   Exactly N_PAT responses are absorbed per run.
//   start_i while in RUN: ignored.
//   abort_i in any state -> IDLE on the next edge: pat_o=0, busy_o=0, done_o=0, pass_o=0.
//     sig_o holds its last value. abort_i has priority over start_i on the same edge.
//   DONE holds pat_o, sig_o and the verdict until a new start_i or abort_i.
//   pat_o never shows 0 during RUN, because the seed is non-zero.
//   cnt width is 8 bits; no wrap is possible within the N_PAT range.
//   No combinational path from any input to any output.
// STRUCTURE
//   Package c17_bist_pkg holds:
//     - state enum
//     - LFSR width/taps constant (5, taps 4 and 2)
//     - MISR width/polynomial constant (16, 16'h1021)
//     - rsp/pat bit-index localparams
//   Sub-module c17_misr is the 16-bit MISR register with load, enable and 2-bit parallel input.
//   LFSR and FSM stay in c17_bist_ctrl.
//   The top-level test harness instantiates c17_bist_ctrl with c17; pat_o and rsp_i are wired per the map above.
// TESTING
//   1. Reset: rst_n=0 -> all outputs 0. Release, then start pulse ->
//      pat_o sequence 01,02,04,09,12,05,... (hex), busy_o=1.
//   2. Full run, c17 attached, GOLDEN_SIG from the model -> done_o exactly 31 cycles after start,
//      pass_o=1, sig_o=GOLDEN_SIG, busy_o=0, pat_o=0.
//   3. Fault: gat_out22 stuck-at-0 in the bench -> done_o after 31 cycles, pass_o=0, sig_o!=GOLDEN_SIG.
//   4. N_PAT=1, rsp_i forced 2'b11, MISR_SEED=0 -> sig_o=16'h0003 and done_o one cycle after start.
//   5. abort_i at cycle 10 of a run with start_i also high -> IDLE next edge, all flags 0.
//      A later start gives the same signature as test 2.
//   6. start_i held high through RUN -> no restart. rst_n pulsed low mid-run -> outputs 0
//      asynchronously, before the next clk edge.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// ============================================================================
//  Module      : c17_bist_pkg
//  Description : Shared types and constants for the c17 BIST controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LFSR_W      = 5;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;

    localparam int                MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    localparam int CNT_W = 8;

    localparam int RSP_OUT22 = 0;
    localparam int RSP_OUT23 = 1;

    localparam int PAT_GAT1 = 0;
    localparam int PAT_GAT2 = 1;
    localparam int PAT_GAT3 = 2;
    localparam int PAT_GAT6 = 3;
    localparam int PAT_GAT7 = 4;

    // x^5 + x^3 + 1 Fibonacci step, maximal length (period 31)
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/c17_bist_if.sv
// ============================================================================
//  Module      : c17_bist_if
//  Description : Control, pattern and response bundle of the c17 BIST block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface c17_bist_if;
    import c17_bist_pkg::*;

    logic              start_i;
    logic              abort_i;
    logic [1:0]        rsp_i;
    logic [LFSR_W-1:0] pat_o;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [MISR_W-1:0] sig_o;

    modport slave (
        input  start_i, abort_i, rsp_i,
        output pat_o, busy_o, done_o, pass_o, sig_o
    );

    modport master (
        output start_i, abort_i, rsp_i,
        input  pat_o, busy_o, done_o, pass_o, sig_o
    );

endinterface

`default_nettype wire

// File: rtl/c17_misr.sv
// ============================================================================
//  Module      : c17_misr
//  Description : 16-bit MISR with seed load, enable and 2-bit parallel input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c17_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [MISR_W-1:0] seed_i,
    input  logic              en_i,
    input  logic [1:0]        d_i,
    output logic [MISR_W-1:0] sig_o,
    output logic [MISR_W-1:0] sig_d_o
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = {sig_q[MISR_W-2:0], 1'b0}
              ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
              ^ {{(MISR_W-2){1'b0}}, d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (load_i) begin
            sig_q <= seed_i;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o   = sig_q;
    assign sig_d_o = sig_d;

endmodule

`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
// ============================================================================
//  Module      : c17_bist_ctrl
//  Description : LFSR pattern driver, MISR observer and verdict FSM for c17.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                N_PAT      = 31,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001,
    parameter logic [MISR_W-1:0] MISR_SEED  = 16'h0000,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    c17_bist_if.slave  bus
);

    state_e            state_q;
    logic [LFSR_W-1:0] pat_q;
    logic [LFSR_W-1:0] pat_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              accept;
    logic              last;
    logic              misr_en;
    logic [MISR_W-1:0] misr_sig;
    logic [MISR_W-1:0] misr_d;

    assign accept  = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                   && bus.start_i && !bus.abort_i;
    assign last    = (cnt_q == CNT_W'(N_PAT - 1));
    assign pat_d   = lfsr_step(pat_q);
    // The response on rsp_i belongs to the pattern currently on pat_o.
    assign misr_en = (state_q == ST_RUN) && !bus.abort_i;

    c17_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .seed_i  (MISR_SEED),
        .en_i    (misr_en),
        .d_i     ({bus.rsp_i[RSP_OUT23], bus.rsp_i[RSP_OUT22]}),
        .sig_o   (misr_sig),
        .sig_d_o (misr_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (bus.abort_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i) begin
                        state_q <= ST_RUN;
                        pat_q   <= LFSR_SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q <= ST_DONE;
                        pat_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (misr_d == GOLDEN_SIG);
                    end else begin
                        pat_q   <= pat_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pat_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pat_o  = pat_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.pass_o = pass_q;
    assign bus.sig_o  = misr_sig;

endmodule

`default_nettype wire

// File: tb/tb_c17_bist_ctrl.sv
// ============================================================================
//  Module      : tb_c17_bist_ctrl
//  Description : Scoreboard bench for c17_bist_ctrl with a c17 gate model attached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c17_bist_ctrl;
    import c17_bist_pkg::*;

    // ---------------- reference model ----------------
    function automatic logic [1:0] c17_model(input logic [4:0] p);
        logic g10, g11, g16, g19;
        g10 = ~(p[PAT_GAT1] & p[PAT_GAT3]);
        g11 = ~(p[PAT_GAT3] & p[PAT_GAT6]);
        g16 = ~(p[PAT_GAT2] & g11);
        g19 = ~(g11 & p[PAT_GAT7]);
        return {~(g16 & g19), ~(g10 & g16)};
    endfunction

    // fault 1: out22 stuck-at-0, 2: out23 stuck-at-1, 3: out22 stuck-at-1
    function automatic logic [1:0] inject(input logic [1:0] r, input int f);
        logic [1:0] o;
        o = r;
        case (f)
            1:       o[0] = 1'b0;
            2:       o[1] = 1'b1;
            3:       o[0] = 1'b1;
            default: o = r;
        endcase
        return o;
    endfunction

    function automatic logic [4:0] pat_at(input int k);
        logic [4:0] p;
        p = 5'b00001;
        for (int i = 0; i < k; i++) p = {p[3:0], 1'b0} | {4'b0000, p[4] ^ p[2]};
        return p;
    endfunction

    // signature as polynomial arithmetic: s = s*x mod (x^16+x^12+x^5+1) + rsp
    function automatic logic [15:0] sig_model(input int n, input int f);
        logic [15:0] s;
        logic [16:0] t;
        s = 16'h0000;
        for (int k = 0; k < n; k++) begin
            t = {s, 1'b0};
            if (t[16]) t = t ^ 17'h11021;
            s = t[15:0] ^ {14'b0, inject(c17_model(pat_at(k)), f)};
        end
        return s;
    endfunction

    localparam logic [15:0] C_GOLDEN = sig_model(31, 0);

    // ---------------- environment ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          fault0;
    logic [1:0]  r1;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int unsigned start;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    c17_bist_if bif0 ();
    c17_bist_if bif1 ();
    assign bif0.rsp_i = inject(c17_model(bif0.pat_o), fault0);
    assign bif1.rsp_i = r1;

    c17_bist_ctrl #(
        .N_PAT(31), .LFSR_SEED(5'b00001), .MISR_SEED(16'h0000), .GOLDEN_SIG(C_GOLDEN)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0));

    c17_bist_ctrl #(
        .N_PAT(1), .LFSR_SEED(5'b00001), .MISR_SEED(16'h0000), .GOLDEN_SIG(16'h0003)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;
    int   pidx = 0;

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && bif0.done_o && !done0_prev) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0 sig",     bif0.sig_o, e.sig);
                chk("dut0 pass",    bif0.pass_o, e.pass);
                chk("dut0 busy",    bif0.busy_o, 1'b0);
                chk("dut0 pat",     bif0.pat_o, 5'h00);
                chk("dut0 latency", cyc - e.start, 32'd31);
            end
        end
        done0_prev <= rst_n && bif0.done_o;
        if (rst_n && bif0.busy_o) begin
            chk("dut0 run pat", bif0.pat_o, pat_at(pidx));
            pidx <= pidx + 1;
        end else begin
            pidx <= 0;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && bif1.done_o && !done1_prev) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1 sig",     bif1.sig_o, e.sig);
                chk("dut1 pass",    bif1.pass_o, e.pass);
                chk("dut1 latency", cyc - e.start, 32'd1);
            end
        end
        done1_prev <= rst_n && bif1.done_o;
        if (rst_n && bif1.busy_o) chk("dut1 run pat", bif1.pat_o, 5'h01);
    end

    // ---------------- stimulus ----------------
    task automatic wait_done0(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n && !seen; i++) begin
            @(negedge clk);
            seen = bif0.done_o;
        end
        if (!seen) chk("dut0 done timeout", 32'd0, 32'd1);
    endtask

    task automatic run0(input int f, input bit hold);
        exp_t e;
        fault0 = f;
        @(negedge clk);
        e.sig   = sig_model(31, f);
        e.pass  = (e.sig == C_GOLDEN);
        e.start = cyc + 1;
        q0.push_back(e);
        bif0.start_i = 1'b1;
        if (hold) repeat (25) @(negedge clk);
        else      @(negedge clk);
        bif0.start_i = 1'b0;
        wait_done0(40);
    endtask

    task automatic run1(input logic [1:0] r);
        exp_t e;
        bit   seen;
        r1 = r;
        @(negedge clk);
        e.sig   = {14'b0, r};
        e.pass  = (r == 2'b11);
        e.start = cyc + 1;
        q1.push_back(e);
        bif1.start_i = 1'b1;
        @(negedge clk);
        bif1.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = bif1.done_o;
        end
        if (!seen) chk("dut1 done timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        fault0 = 0;
        r1 = 2'b11;
        bif0.start_i = 1'b0;
        bif0.abort_i = 1'b0;
        bif1.start_i = 1'b0;
        bif1.abort_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset pat",  bif0.pat_o, 5'h00);
        chk("reset busy", bif0.busy_o, 1'b0);
        chk("reset done", bif0.done_o, 1'b0);
        chk("reset pass", bif0.pass_o, 1'b0);
        chk("reset sig",  bif0.sig_o, 16'h0000);
        chk("reset dut1 sig", bif1.sig_o, 16'h0000);
        rst_n = 1'b1;

        run0(0, 1'b0);          // fault-free run
        run0(1, 1'b0);          // out22 stuck-at-0
        run1(2'b11);            // single pattern, forced response

        // abort at cycle 10 of a run with start also high
        fault0 = 0;
        @(negedge clk);
        bif0.start_i = 1'b1;
        @(negedge clk);
        bif0.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bif0.abort_i = 1'b1;
        bif0.start_i = 1'b1;
        @(negedge clk);
        bif0.abort_i = 1'b0;
        bif0.start_i = 1'b0;
        chk("abort busy", bif0.busy_o, 1'b0);
        chk("abort done", bif0.done_o, 1'b0);
        chk("abort pass", bif0.pass_o, 1'b0);
        chk("abort pat",  bif0.pat_o, 5'h00);
        chk("abort sig",  bif0.sig_o, sig_model(10, 0));
        repeat (3) @(negedge clk);
        chk("abort stays idle", bif0.busy_o, 1'b0);
        run0(0, 1'b0);          // same signature as the clean run
        run0(0, 1'b1);          // start held high inside the run

        // asynchronous reset mid-run
        @(negedge clk);
        bif0.start_i = 1'b1;
        @(negedge clk);
        bif0.start_i = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst pat",  bif0.pat_o, 5'h00);
        chk("async rst busy", bif0.busy_o, 1'b0);
        chk("async rst done", bif0.done_o, 1'b0);
        chk("async rst pass", bif0.pass_o, 1'b0);
        chk("async rst sig",  bif0.sig_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run0(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            run1(2'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clk);
        chk("dut0 queue drained", q0.size(), 32'd0);
        chk("dut1 queue drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
